// File: rtl/insn_fetch_queue_if.sv
// Fetch-queue bundle: memory fetch handshake, redirect, decode-side head entry.
// Latency: none (wiring only).
// Backpressure: mem_req_out/mem_ack_in on the memory side, stall_in on the decode side.
// master: the queue (drives requests and head entry); slave: memory + decode environment.
`timescale 1ns/1ps
interface insn_fetch_queue_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // memory side
    logic              mem_req_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_ack_in;
    logic [XLEN-1:0]   mem_data_in;
    // redirect
    logic              flush_in;
    logic [ADDR_W-1:0] flush_pc_in;
    // decode side
    logic              stall_in;
    logic [XLEN-1:0]   insn_out;
    logic [ADDR_W-1:0] insn_pc_out;
    logic              insn_valid_out;
    logic [CNT_W-1:0]  count_out;

    modport master (
        output mem_req_out, mem_addr_out,
        input  mem_ack_in, mem_data_in,
        input  flush_in, flush_pc_in,
        input  stall_in,
        output insn_out, insn_pc_out, insn_valid_out, count_out
    );

    modport slave (
        input  mem_req_out, mem_addr_out,
        output mem_ack_in, mem_data_in,
        output flush_in, flush_pc_in,
        output stall_in,
        input  insn_out, insn_pc_out, insn_valid_out, count_out
    );
endinterface

// File: rtl/insn_fetch_queue.sv
// Instruction prefetch queue: sequential fetch, DEPTH-entry FIFO of {insn, pc}, flush redirect.
// Latency: word acked in cycle N is on insn_out in cycle N+1 (empty queue); 1 insn/cycle sustained.
// Backpressure: mem_req_out drops when full or flushing; stall_in holds the head entry.
// Ports: clk_in (rising edge), reset_in (async, active low), bus (insn_fetch_queue_if.master):
//   mem_req_out/mem_addr_out/mem_ack_in/mem_data_in fetch handshake, flush_in/flush_pc_in redirect,
//   stall_in decode stall, insn_out/insn_pc_out/insn_valid_out head entry, count_out occupancy.
`timescale 1ns/1ps
module insn_fetch_queue #(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0]   NOP_INSN = '0
) (
    input  logic                clk_in,
    input  logic                reset_in,
    insn_fetch_queue_if.master  bus
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_INC);

    // entry storage; no reset needed, contents are only visible while count != 0
    logic [XLEN-1:0]   insn_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_pc;

    logic req;
    logic push;
    logic pop;
    logic valid;

    assign valid = (count != '0);

    // Request is gated by reset_in so it drops the moment reset asserts, and by
    // flush_in so no word is accepted into a queue that is being discarded.
    // It uses the registered count, so a full queue never pushes even if it pops.
    assign req  = reset_in & (count < FULL_CNT) & ~bus.flush_in;
    assign push = req & bus.mem_ack_in;
    assign pop  = valid & ~bus.stall_in;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
        end else if (bus.flush_in) begin
            // redirect wins over any ack or pop in the same cycle
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= bus.flush_pc_in;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            insn_q[wr_ptr] <= bus.mem_data_in;
            pc_q[wr_ptr]   <= fetch_pc;
        end
    end

    assign bus.mem_req_out    = req;
    assign bus.mem_addr_out   = fetch_pc;
    assign bus.insn_valid_out = valid;
    assign bus.insn_out       = valid ? insn_q[rd_ptr] : NOP_INSN;
    assign bus.insn_pc_out    = valid ? pc_q[rd_ptr] : '0;
    assign bus.count_out      = count;
endmodule

// File: tb/tb_insn_fetch_queue.sv
`timescale 1ns/1ps
module tb_insn_fetch_queue;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk;
    logic reset_in;

    insn_fetch_queue_if #(.XLEN(32), .ADDR_W(32), .DEPTH(4)) bus1 ();
    insn_fetch_queue_if #(.XLEN(32), .ADDR_W(32), .DEPTH(4)) bus2 ();

    insn_fetch_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(4), .PC_INC(4),
                       .RESET_PC(32'h0), .NOP_INSN(32'h0)) dut1 (
        .clk_in   (clk),
        .reset_in (reset_in),
        .bus      (bus1)
    );

    insn_fetch_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(4), .PC_INC(4),
                       .RESET_PC(32'hFFFF_FFF8), .NOP_INSN(32'h0)) dut2 (
        .clk_in   (clk),
        .reset_in (reset_in),
        .bus      (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic        stall;
        logic        flush;
        logic [31:0] fpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic ack, input logic stall, input logic flush,
                                input logic [31:0] fpc, input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.ack = ack; v.stall = stall; v.flush = flush; v.fpc = fpc;
        v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc; v.exp_cnt = cnt;
        return v;
    endfunction

    vec_t vecs [26];
    logic [31:0] exp2_addr [4];

    initial begin
        logic [31:0] exp_insn;

        //             ack st fl fpc        req addr      vld pc         cnt
        // streaming from reset, data = addr ^ KEY
        vecs[0]  = mk(1, 0, 0, 32'h0,   1, 32'h00,  0, 32'h0,   3'd0);
        vecs[1]  = mk(1, 0, 0, 32'h0,   1, 32'h04,  1, 32'h0,   3'd1);
        vecs[2]  = mk(1, 0, 0, 32'h0,   1, 32'h08,  1, 32'h4,   3'd1);
        vecs[3]  = mk(1, 0, 0, 32'h0,   1, 32'h0C,  1, 32'h8,   3'd1);
        // stall fills the queue; request drops when full
        vecs[4]  = mk(1, 1, 0, 32'h0,   1, 32'h10,  1, 32'hC,   3'd1);
        vecs[5]  = mk(1, 1, 0, 32'h0,   1, 32'h14,  1, 32'hC,   3'd2);
        vecs[6]  = mk(1, 1, 0, 32'h0,   1, 32'h18,  1, 32'hC,   3'd3);
        vecs[7]  = mk(1, 1, 0, 32'h0,   0, 32'h1C,  1, 32'hC,   3'd4);
        // full and pop: no push this cycle, request back next cycle
        vecs[8]  = mk(1, 0, 0, 32'h0,   0, 32'h1C,  1, 32'hC,   3'd4);
        vecs[9]  = mk(1, 0, 0, 32'h0,   1, 32'h1C,  1, 32'h10,  3'd3);
        vecs[10] = mk(0, 1, 0, 32'h0,   1, 32'h20,  1, 32'h14,  3'd3);
        // flush at count 3 with ack: ack discarded
        vecs[11] = mk(1, 0, 1, 32'h100, 0, 32'h20,  1, 32'h14,  3'd3);
        vecs[12] = mk(0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   3'd0);
        vecs[13] = mk(1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   3'd0);
        vecs[14] = mk(1, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100, 3'd1);
        vecs[15] = mk(1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h104, 3'd1);
        // ack low for 5 cycles: address stable, queue drains to empty
        vecs[16] = mk(0, 0, 0, 32'h0,   1, 32'h10C, 1, 32'h104, 3'd2);
        vecs[17] = mk(0, 0, 0, 32'h0,   1, 32'h10C, 1, 32'h108, 3'd1);
        vecs[18] = mk(0, 0, 0, 32'h0,   1, 32'h10C, 0, 32'h0,   3'd0);
        vecs[19] = mk(0, 0, 0, 32'h0,   1, 32'h10C, 0, 32'h0,   3'd0);
        vecs[20] = mk(0, 1, 0, 32'h0,   1, 32'h10C, 0, 32'h0,   3'd0);
        // back-to-back flushes: last target wins
        vecs[21] = mk(1, 0, 1, 32'h200, 0, 32'h10C, 0, 32'h0,   3'd0);
        vecs[22] = mk(1, 0, 1, 32'h300, 0, 32'h200, 0, 32'h0,   3'd0);
        vecs[23] = mk(1, 0, 0, 32'h0,   1, 32'h300, 0, 32'h0,   3'd0);
        vecs[24] = mk(0, 0, 0, 32'h0,   1, 32'h304, 1, 32'h300, 3'd1);
        vecs[25] = mk(0, 1, 0, 32'h0,   1, 32'h304, 0, 32'h0,   3'd0);

        exp2_addr[0] = 32'hFFFF_FFF8;
        exp2_addr[1] = 32'hFFFF_FFFC;
        exp2_addr[2] = 32'h0000_0000;
        exp2_addr[3] = 32'h0000_0004;

        // reset with ack already high: request must stay low
        reset_in = 1'b0;
        bus1.mem_ack_in = 1'b1; bus1.mem_data_in = 32'h0; bus1.stall_in = 1'b0;
        bus1.flush_in = 1'b0;   bus1.flush_pc_in = 32'h0;
        bus2.mem_ack_in = 1'b1; bus2.mem_data_in = 32'h0; bus2.stall_in = 1'b0;
        bus2.flush_in = 1'b0;   bus2.flush_pc_in = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.req",   32'(bus1.mem_req_out),    32'h0);
        chk("rst.addr",  bus1.mem_addr_out,        32'h0);
        chk("rst.valid", 32'(bus1.insn_valid_out), 32'h0);
        chk("rst.insn",  bus1.insn_out,            32'h0);
        chk("rst.pc",    bus1.insn_pc_out,         32'h0);
        chk("rst.count", 32'(bus1.count_out),      32'h0);
        chk("rst.req2",  32'(bus2.mem_req_out),    32'h0);
        chk("rst.addr2", bus2.mem_addr_out,        32'hFFFF_FFF8);
        reset_in = 1'b1;

        for (int i = 0; i < 26; i++) begin
            bus1.mem_ack_in  = vecs[i].ack;
            bus1.stall_in    = vecs[i].stall;
            bus1.flush_in    = vecs[i].flush;
            bus1.flush_pc_in = vecs[i].fpc;
            bus1.mem_data_in = vecs[i].exp_addr ^ KEY;
            #1;
            exp_insn = vecs[i].exp_valid ? (vecs[i].exp_pc ^ KEY) : 32'h0;
            chk($sformatf("v%0d.req", i),   32'(bus1.mem_req_out),    32'(vecs[i].exp_req));
            chk($sformatf("v%0d.addr", i),  bus1.mem_addr_out,        vecs[i].exp_addr);
            chk($sformatf("v%0d.valid", i), 32'(bus1.insn_valid_out), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d.pc", i),    bus1.insn_pc_out,         vecs[i].exp_pc);
            chk($sformatf("v%0d.insn", i),  bus1.insn_out,            exp_insn);
            chk($sformatf("v%0d.count", i), 32'(bus1.count_out),      32'(vecs[i].exp_cnt));
            if (i < 4) begin
                chk($sformatf("wrap%0d.addr", i), bus2.mem_addr_out, exp2_addr[i]);
            end
            @(posedge clk);
            #1;
        end

        // mid-cycle reset with two words queued and request high
        bus1.mem_ack_in  = 1'b1;
        bus1.stall_in    = 1'b1;
        bus1.flush_in    = 1'b0;
        bus1.mem_data_in = 32'h1234_5678;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre.count", 32'(bus1.count_out),   32'd2);
        chk("pre.req",   32'(bus1.mem_req_out), 32'h1);
        chk("pre.addr",  bus1.mem_addr_out,     32'h30C);
        #1;
        reset_in = 1'b0;
        #1;
        chk("arst.req",   32'(bus1.mem_req_out),    32'h0);
        chk("arst.addr",  bus1.mem_addr_out,        32'h0);
        chk("arst.valid", 32'(bus1.insn_valid_out), 32'h0);
        chk("arst.insn",  bus1.insn_out,            32'h0);
        chk("arst.pc",    bus1.insn_pc_out,         32'h0);
        chk("arst.count", 32'(bus1.count_out),      32'h0);
        chk("arst.addr2", bus2.mem_addr_out,        32'hFFFF_FFF8);
        #1;
        reset_in = 1'b1;
        #1;
        chk("rel.req",  32'(bus1.mem_req_out), 32'h1);
        chk("rel.addr", bus1.mem_addr_out,     32'h0);
        @(posedge clk);
        #1;
        chk("rel2.addr",  bus1.mem_addr_out,        32'h4);
        chk("rel2.valid", 32'(bus1.insn_valid_out), 32'h1);
        chk("rel2.pc",    bus1.insn_pc_out,         32'h0);
        chk("rel2.insn",  bus1.insn_out,            32'h1234_5678);
        chk("rel2.count", 32'(bus1.count_out),      32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
